// File: rtl/trapez_peak_sampler_pkg.sv
// trapez_peak_sampler_pkg
//   Shared settings for the trapezoidal shaper back end. It holds the data and
//   constant widths, the peak sampler state encoding, and a helper that clamps
//   the rise length. A zero rise length would otherwise make the rise phase
//   end before it starts.
package trapez_peak_sampler_pkg;

  localparam int SIZE_SHAPER_DATA     = 16;
  localparam int SIZE_SHAPER_CONSTANT = 8;
  localparam int SIZE_SHAPER_ENERGY   = SIZE_SHAPER_DATA;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    FLAT,
    FALL
  } peak_state_t;

  // The rise phase has to last at least one cycle, so a programmed length of
  // zero is treated as one.
  function automatic logic [SIZE_SHAPER_CONSTANT-1:0] kEffective(
    input logic [SIZE_SHAPER_CONSTANT-1:0] k
  );
    return (k == '0) ? SIZE_SHAPER_CONSTANT'(1) : k;
  endfunction

endpackage

// File: rtl/trapez_flat_avg.sv
// trapez_flat_avg
//   Flat-top averager. It clears, accumulates signed samples, and presents the
//   accumulator divided by 2^AVG_LOG2 through an arithmetic shift.
// Ports
//   clk       in   system clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   clear_i   in   zero the accumulator (takes priority over accum_i)
//   accum_i   in   add sample_i into the accumulator this cycle
//   sample_i  in   signed sample, SIZE_SHAPER_DATA bits
//   avg_o     out  accumulator >>> AVG_LOG2, low SIZE_SHAPER_DATA bits
module trapez_flat_avg
  import trapez_peak_sampler_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                        clk,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        accum_i,
  input  logic [SIZE_SHAPER_DATA-1:0] sample_i,
  output logic [SIZE_SHAPER_DATA-1:0] avg_o
);

  // The extra AVG_LOG2 bits hold the sum of 2^AVG_LOG2 full-scale samples
  // without overflow.
  localparam int ACC_W = SIZE_SHAPER_DATA + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sampleExt;

  // Next-state accumulator. Clearing at pulse start wins over accumulation.
  always_comb begin
    sampleExt = ACC_W'($signed(sample_i));
    acc_d     = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (accum_i) begin
      acc_d = acc_q + sampleExt;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Arithmetic shift keeps the sign, so negative pulses average correctly.
  assign avg_o = SIZE_SHAPER_DATA'(acc_q >>> AVG_LOG2);

endmodule

// File: rtl/trapez_peak_sampler.sv
// trapez_peak_sampler
//   Downstream stage of the trapezoidal shaper. A pulse is detected when the
//   shaped stream crosses the threshold. The block skips the rise and the
//   flat-top offset, then averages 2^AVG_LOG2 flat-top samples. When the
//   signal falls back to or below the threshold, it delivers one energy word
//   per pulse through a valid/ready result slot.
//   - Triggers seen during a pulse mark that pulse as piled up.
//   - A pulse that stays above threshold for too long is aborted.
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   enable                      block enable, low aborts the current pulse
//   shaped_data, threshold      signed shaped stream and detection level
//   trig                        upstream discriminator pulse
//   k_trapez, l_trapez          rise and flat-top lengths in cycles
//   flat_offset                 cycles after the rise before averaging starts
//   reject_pileup               drop piled-up results instead of flagging them
//   energy, energy_pileup       result word and pile-up flag
//   energy_valid, energy_ready  result slot handshake
//   cfg_err                     sticky: averaging window exceeds flat top
//   lost_cnt, pileup_cnt,       saturating event counters
//   timeout_cnt
module trapez_peak_sampler
  import trapez_peak_sampler_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [SIZE_SHAPER_DATA-1:0]     shaped_data,
  input  logic                            trig,
  input  logic [SIZE_SHAPER_DATA-1:0]     threshold,
  input  logic [SIZE_SHAPER_CONSTANT-1:0] k_trapez,
  input  logic [SIZE_SHAPER_CONSTANT-1:0] l_trapez,
  input  logic [SIZE_SHAPER_CONSTANT-1:0] flat_offset,
  input  logic                            reject_pileup,
  output logic [SIZE_SHAPER_ENERGY-1:0]   energy,
  output logic                            energy_pileup,
  output logic                            energy_valid,
  input  logic                            energy_ready,
  output logic                            cfg_err,
  output logic [CNT_W-1:0]                lost_cnt,
  output logic [CNT_W-1:0]                pileup_cnt,
  output logic [CNT_W-1:0]                timeout_cnt
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int CW = SIZE_SHAPER_CONSTANT + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  peak_state_t                     state_q;
  logic [CW-1:0]                   cnt_q;
  logic [TW-1:0]                   tmo_q;
  logic                            pileup_q;
  logic [SIZE_SHAPER_ENERGY-1:0]   energy_q;
  logic                            energyPileup_q;
  logic                            energyValid_q;
  logic                            cfgErr_q;
  logic [CNT_W-1:0]                lost_q;
  logic [CNT_W-1:0]                pileupCnt_q;
  logic [CNT_W-1:0]                timeoutCnt_q;

  logic                            above;
  logic [CW-1:0]                   riseLast;
  logic                            cfgBad;
  logic                            startPulse;
  logic                            consumed;
  logic                            pileupNow;
  logic [SIZE_SHAPER_DATA-1:0]     avg;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pulse detection and phase bookkeeping.
  // - The rise phase ends after k_eff + flat_offset cycles.
  // - The configuration is rejected when the averaging window would run past
  //   the end of the flat top.
  // - A trigger arriving on the delivering FALL cycle still counts as pile-up.
  always_comb begin
    above      = $signed(shaped_data) > $signed(threshold);
    riseLast   = CW'(kEffective(k_trapez)) + CW'(flat_offset) - CW'(1);
    cfgBad     = (CW'(flat_offset) + CW'(N)) > CW'(l_trapez);
    startPulse = (state_q == IDLE) && enable && above && !cfgBad;
    consumed   = energyValid_q && energy_ready;
    pileupNow  = pileup_q || trig;
  end

  trapez_flat_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst_ni   (reset),
    .clear_i  (startPulse),
    .accum_i  (state_q == FLAT),
    .sample_i (shaped_data),
    .avg_o    (avg)
  );

  // Main FSM with registered outputs.
  // - Precedence while a pulse is in flight: an enable drop aborts silently,
  //   then the timeout aborts and counts, then the normal phase progression.
  // - The result slot clears on a handshake, but a delivery on the same edge
  //   reloads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tmo_q          <= '0;
      pileup_q       <= 1'b0;
      energy_q       <= '0;
      energyPileup_q <= 1'b0;
      energyValid_q  <= 1'b0;
      cfgErr_q       <= 1'b0;
      lost_q         <= '0;
      pileupCnt_q    <= '0;
      timeoutCnt_q   <= '0;
    end else begin
      if (consumed) begin
        energyValid_q <= 1'b0;
      end
      if (state_q != IDLE && trig) begin
        pileup_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (enable && above) begin
            if (cfgBad) begin
              cfgErr_q <= 1'b1;
            end else begin
              state_q  <= RISE;
              cnt_q    <= '0;
              tmo_q    <= '0;
              pileup_q <= 1'b0;
            end
          end
        end
        default: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q      <= IDLE;
            timeoutCnt_q <= satInc(timeoutCnt_q);
          end else begin
            tmo_q <= tmo_q + 1'b1;
            case (state_q)
              RISE: begin
                if (cnt_q == riseLast) begin
                  state_q <= FLAT;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end
              FLAT: begin
                if (cnt_q == CW'(N - 1)) begin
                  state_q <= FALL;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end
              FALL: begin
                if (!above) begin
                  state_q <= IDLE;
                  if (pileupNow && reject_pileup) begin
                    pileupCnt_q <= satInc(pileupCnt_q);
                  end else if (!energyValid_q || consumed) begin
                    energy_q       <= avg;
                    energyPileup_q <= pileupNow;
                    energyValid_q  <= 1'b1;
                  end else begin
                    lost_q <= satInc(lost_q);
                  end
                end
              end
              default: begin
                state_q <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign energy        = energy_q;
  assign energy_pileup = energyPileup_q;
  assign energy_valid  = energyValid_q;
  assign cfg_err       = cfgErr_q;
  assign lost_cnt      = lost_q;
  assign pileup_cnt    = pileupCnt_q;
  assign timeout_cnt   = timeoutCnt_q;

endmodule
